// File: rtl/dispatch_queue.sv
// dispatch_queue: circular FIFO of {valid, payload} entries between dispatch
// and issue. Supports per-slot squash, automatic discard of invalidated head
// entries, full/empty flow control and a sticky overflow flag.
// Optional feature macro: DISPATCH_QUEUE_REPORT_EN builds a free-running
// cycle counter and prints a state report on each edge with report=1.
module dispatch_queue #(
  parameter int CORE        = 0,
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   write,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_valid,
  input  logic                   read,
  input  logic                   squash,
  input  logic [INDEX_WIDTH-1:0] squash_address,
  output logic                   out_valid,
  output logic [DATA_WIDTH:0]    out_data,
  output logic [INDEX_WIDTH-1:0] out_address,
  output logic [INDEX_WIDTH:0]   count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  input  logic                   report
);

  localparam int DEPTH = 1 << INDEX_WIDTH;
  localparam logic [INDEX_WIDTH:0]   DEPTH_C = {1'b1, {INDEX_WIDTH{1'b0}}};
  localparam logic [INDEX_WIDTH-1:0] PTR_ONE = {{(INDEX_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [INDEX_WIDTH:0]   CNT_ONE = {{INDEX_WIDTH{1'b0}}, 1'b1};

  // Payload storage is never reset; occupancy is tracked by head/count.
  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
  logic [DEPTH-1:0]       vld_q, vld_d;
  logic [INDEX_WIDTH-1:0] head_q, head_d;
  logic [INDEX_WIDTH-1:0] tail_q, tail_d;
  logic [INDEX_WIDTH:0]   count_q, count_d;
  logic                   overflow_q, overflow_d;

  logic                   head_vld;
  logic                   do_enq;
  logic                   do_deq;
  logic                   do_drop;
  logic                   sq_hit;
  logic [INDEX_WIDTH-1:0] sq_dist;

  // Outputs are purely functions of registered state.
  always_comb begin
    empty       = (count_q == '0);
    full        = (count_q == DEPTH_C);
    head_vld    = vld_q[head_q];
    out_valid   = !empty && head_vld;
    out_address = head_q;
    out_data    = out_valid ? {1'b1, mem_q[head_q]} : '0;
    count       = count_q;
    overflow    = overflow_q;
  end

  // Next-state: enqueue, dequeue/auto-drop, squash and overflow tracking.
  always_comb begin
    do_enq  = write && !full;
    do_deq  = read && out_valid;
    do_drop = !empty && !head_vld;
    // Slot is occupied when its distance from head (mod depth) is below count.
    // A squash of the head being dequeued this edge is a no-op.
    sq_dist = squash_address - head_q;
    sq_hit  = squash && ({1'b0, sq_dist} < count_q) &&
              !(do_deq && (squash_address == head_q));

    vld_d      = vld_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (sq_hit) vld_d[squash_address] = 1'b0;
    // The enqueue slot is never occupied pre-edge, so it cannot collide with
    // a squash hit; the new entry keeps in_valid.
    if (do_enq) begin
      vld_d[tail_q] = in_valid;
      tail_d        = tail_q + PTR_ONE;
    end
    if (write && full) overflow_d = 1'b1;

    if (do_deq || do_drop) head_d = head_q + PTR_ONE;

    case ({do_enq, do_deq || do_drop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      vld_q      <= vld_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload write port; contents survive reset but are unreachable afterwards.
  always_ff @(posedge clock) begin
    if (do_enq) mem_q[tail_q] <= in_data;
  end

`ifdef DISPATCH_QUEUE_REPORT_EN
  logic [31:0] cycle_q, cycle_d;

  always_comb cycle_d = cycle_q + 32'd1;

  // Free-running cycle stamp for the debug report.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cycle_q <= '0;
    else        cycle_q <= cycle_d;
  end

  // Debug report of pre-edge state and the inputs seen at this edge.
  always @(posedge clock) begin
    if (reset && report)
      $display("dispatch_queue core=%0d cycle=%0d head=%0d tail=%0d count=%0d full=%0b empty=%0b overflow=%0b out_valid=%0b out_data=%h in_data=%h in_valid=%0b write=%0b read=%0b squash=%0b",
               CORE, cycle_q, head_q, tail_q, count_q, full, empty, overflow_q,
               out_valid, out_data, in_data, in_valid, write, read, squash);
  end
`else
  logic unused_report;
  assign unused_report = report;
`endif

endmodule

// File: doc/dispatch_queue.md
# dispatch_queue

Parametrised circular dispatch buffer that holds up to 2^INDEX_WIDTH entries, each a data word plus a valid bit, and hands them out in FIFO order. Sits between a core's dispatch stage and its issue logic, replacing single-address dispatch storage with a depth-configurable queue. Adds full/empty flow control, per-slot squash, automatic discard of invalidated head entries, an overflow flag and a cycle-stamped debug report.

## Interface
- CORE, 0, core index printed in reports
- DATA_WIDTH, 32, payload width
- INDEX_WIDTH, 8, slot address width; depth = 2^INDEX_WIDTH
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- write  in  1  enqueue request
- in_data  in  DATA_WIDTH  payload to enqueue
- in_valid  in  1  valid bit stored with the payload
- read  in  1  dequeue request
- squash  in  1  invalidate request
- squash_address  in  INDEX_WIDTH  slot to invalidate
- out_valid  out  1  head present and valid
- out_data  out  DATA_WIDTH+1  {valid, payload} of head; 0 when out_valid=0
- out_address  out  INDEX_WIDTH  head slot index
- count  out  INDEX_WIDTH+1  occupied slots, including invalidated ones
- full  out  1  count == depth
- empty  out  1  count == 0
- overflow  out  1  sticky: write attempted while full
- report  in  1  print state this cycle

## Operation
- Storage: depth × (DATA_WIDTH+1) array, head and tail pointers (INDEX_WIDTH bits, natural wrap from depth−1 to 0), count register.
- Enqueue: write && !full → slot[tail] ← {in_valid, in_data}, tail+1.
- Write while full: dropped, overflow ← 1; overflow clears only on reset.
- out_valid = !empty && slot[head].valid; out_address = head; out_data = slot[head] when out_valid, else 0.
- Dequeue: read && out_valid → head+1. read with out_valid=0 is ignored.
- Auto-drop: !empty && slot[head].valid == 0 → head+1 with no read needed; one entry per cycle.
- Squash: squash && slot occupied (distance from head < count, pre-edge) → slot.valid ← 0. Unoccupied slot: ignored.
- count: +1 on enqueue, −1 on dequeue or auto-drop, unchanged when both happen.
- full, empty and out_valid use pre-edge state. Dequeue/drop and enqueue in the same cycle while full still drops the write and sets overflow.
- Squash targeting head while read && out_valid: the dequeue completes and the squash is a no-op.
- Squash targeting the slot being enqueued: slot is unoccupied pre-edge, so the squash is ignored and the new entry keeps in_valid.
- in_valid=0 entries are stored and later auto-dropped, never presented.

## Timing
- Reset (reset=0, asynchronous): head=tail=0, count=0, all valid bits 0, overflow=0, cycle counter=0. Outputs: out_valid=0, out_data=0, out_address=0, count=0, empty=1, full=0.
- Payload bits are not reset.
- Reset asserted mid-operation discards all entries immediately.
- Enqueue to dequeue latency is 1 cycle. An entry written at edge N is visible on out_* after edge N, and can be dequeued at edge N+1.
- Squash takes effect at the edge. An invalidated head is auto-dropped at the next edge.
- Outputs are combinational from registers. There are no input-to-output combinational paths.

## Configuration
- DISPATCH_QUEUE_REPORT_EN defined:
  - A free-running 32-bit cycle counter is built.
  - On each edge with report=1, print: core, cycle, head, tail, count, full, empty, overflow, out_valid, out_data, and in_data/in_valid/write/read/squash.
- Undefined: the counter and $display are compiled out, and report is ignored.
- Queue behaviour is identical with and without the macro.

## Test plan
Parameters: DATA_WIDTH=8, INDEX_WIDTH=2.
- Reset, then write 0x11,0x22,0x33,0x44 with in_valid=1 on consecutive cycles → full=1, count=4. Then read ×4 → out_data 0x111, 0x122, 0x133, 0x144 in order, empty=1.
- Fill to 4 entries, write 0x55 → overflow=1, count=4, 0x55 never appears. Overflow stays 1 until reset.
- Fill to 4 entries, then read and write 0x66 in the same cycle → write dropped, count=3, overflow=1.
- Enqueue 0xA0, 0xA1, 0xA2 (head at slot 0), squash slot 1, then read repeatedly → outputs 0x1A0, then 0x1A2. Slot 1 is auto-dropped with no out_valid cycle for it.
- Enqueue 0x10 with in_valid=0, then 0x20 with in_valid=1 → 0x10 is auto-dropped in one cycle, out_data=0x120 at out_address=1, count=1.
- Enqueue 7 and dequeue 7 entries to wrap the pointers, then assert reset=0 asynchronously between clock edges → all outputs reach their reset values without a clock edge.
